// File: rtl/platform_ledr_arbiter.sv
// platform_ledr_arbiter: round-robin arbiter and write sequencer sharing the LEDR PIO
// among NREQ requesters. Each grant becomes one PIO write at address 0, then an ack.
// Define LEDR_ARB_READBACK_EN to add a read-back check state and the sticky rb_err flag.
module platform_ledr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned DW   = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      ack,
    output logic                 busy,
    output logic [2:0]           grant_idx,
    output logic [1:0]           pio_address,
    output logic                 pio_chipselect,
    output logic                 pio_write_n,
    output logic [31:0]          pio_writedata,
    input  logic [31:0]          pio_readdata,
    output logic                 rb_err,
    input  logic                 err_clr
);

    localparam int unsigned IW = 3;
    localparam int unsigned PW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
`ifdef LEDR_ARB_READBACK_EN
        ST_READ  = 2'd2,
`endif
        ST_ACK   = 2'd3
    } state_t;

    state_t          state, state_d;
    logic [IW-1:0]   rr_ptr, rr_ptr_d;
    logic [IW-1:0]   grant_d;
    logic [NREQ-1:0] ack_d;
    logic            busy_d;
    logic            cs_d;
    logic            wr_n_d;
    logic [PW-1:0]   wdata_d;
    logic [IW-1:0]   sel_idx;
    logic [DW-1:0]   sel_data;

    // The PIO has a single data register; the address never changes.
    assign pio_address = 2'b00;

    // Round-robin pick: lowest active index at or after rr_ptr, else lowest below it.
    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        for (int j = int'(NREQ) - 1; j >= 0; j--) begin
            if (req[j] && (IW'(j) < rr_ptr)) begin
                sel_idx  = IW'(j);
                sel_data = req_data[j*DW +: DW];
            end
        end
        for (int j = int'(NREQ) - 1; j >= 0; j--) begin
            if (req[j] && (IW'(j) >= rr_ptr)) begin
                sel_idx  = IW'(j);
                sel_data = req_data[j*DW +: DW];
            end
        end
    end

    // Next state and next registered outputs; outputs are one cycle ahead of the state.
    always_comb begin
        state_d  = state;
        rr_ptr_d = rr_ptr;
        grant_d  = grant_idx;
        ack_d    = '0;
        cs_d     = 1'b0;
        wr_n_d   = 1'b1;
        wdata_d  = pio_writedata;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_WRITE;
                    grant_d = sel_idx;
                    wdata_d = PW'(sel_data);
                    cs_d    = 1'b1;
                    wr_n_d  = 1'b0;
                end
            end
            ST_WRITE: begin
`ifdef LEDR_ARB_READBACK_EN
                state_d = ST_READ;
                cs_d    = 1'b1;
                wr_n_d  = 1'b1;
`else
                state_d = ST_ACK;
                ack_d   = NREQ'(1) << grant_idx;
`endif
            end
`ifdef LEDR_ARB_READBACK_EN
            ST_READ: begin
                state_d = ST_ACK;
                ack_d   = NREQ'(1) << grant_idx;
            end
`endif
            ST_ACK: begin
                state_d  = ST_IDLE;
                rr_ptr_d = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset drops the PIO strobes immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            grant_idx      <= '0;
            ack            <= '0;
            busy           <= 1'b0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
        end else begin
            state          <= state_d;
            rr_ptr         <= rr_ptr_d;
            grant_idx      <= grant_d;
            ack            <= ack_d;
            busy           <= busy_d;
            pio_chipselect <= cs_d;
            pio_write_n    <= wr_n_d;
            pio_writedata  <= wdata_d;
        end
    end

`ifdef LEDR_ARB_READBACK_EN
    logic unused_inputs;
    assign unused_inputs = ^pio_readdata;

    // Sticky read-back mismatch flag; a clear wins over a same-cycle mismatch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rb_err <= 1'b0;
        end else if (err_clr) begin
            rb_err <= 1'b0;
        end else if ((state == ST_READ) && (pio_readdata[DW-1:0] != pio_writedata[DW-1:0])) begin
            rb_err <= 1'b1;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{pio_readdata, err_clr};
    assign rb_err        = 1'b0;
`endif

endmodule

// File: doc/platform_ledr_arbiter.md
# platform_ledr_arbiter

Round-robin arbiter and write sequencer that shares the 10-bit LEDR PIO slave among NREQ independent requesters (CPU-side status, debug heartbeat, cache-miss indicators, ...). It sits between the requesters and the PIO's Avalon-MM slave port. Each accepted request is converted into a single PIO register write at address 0, optionally followed by a read-back check, then acknowledged to the requester.

## Interface
- NREQ, 2, number of requesters (2..8)
- DW, 10, LED data width; must not exceed 32
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  reset; asynchronous, active-low
- req  in  NREQ  per-requester request level; held until the matching ack
- req_data  in  NREQ*DW  requester i's LED value in bits [i*DW +: DW]
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- busy  out  1  high whenever the FSM is not in IDLE
- grant_idx  out  3  index of the last granted requester
- pio_address  out  2  PIO register address, always 0
- pio_chipselect  out  1  PIO chip select
- pio_write_n  out  1  PIO write strobe, active-low
- pio_writedata  out  32  {(32-DW)'b0, latched data}
- pio_readdata  in  32  PIO read data; combinational in the slave, valid in the same cycle
- rb_err  out  1  sticky read-back mismatch flag (readback build only, else tied 0)
- err_clr  in  1  synchronous clear of rb_err

## Operation
- FSM states: IDLE, WRITE, READ (readback build only), ACK.
- IDLE: if any req is high, select the first requester at or after rr_ptr (ascending index, wrapping). Latch its req_data and index, then go to WRITE. If no req is high, stay in IDLE.
- WRITE: drive pio_chipselect=1, pio_write_n=0, pio_address=0 and pio_writedata = the latched data. Next state is READ in the readback build, otherwise ACK.
- READ: drive pio_chipselect=1, pio_write_n=1, pio_address=0. Compare pio_readdata[DW-1:0] with the latched data. On mismatch, set rb_err. Next state is ACK.
- ACK: assert ack[grant] for this cycle only. Set rr_ptr to (grant+1) mod NREQ, then return to IDLE.
- Data is sampled only at grant. Changes to req_data after grant have no effect on the write in progress.
- A req that drops before it is granted is ignored: no write and no ack.
- A requester must drop req in the cycle after its ack, or it is treated as a new request.
- err_clr has priority over a same-cycle mismatch set, so rb_err reads 0 the next cycle.
- Reset mid-operation: the FSM returns to IDLE immediately. The pending transaction is abandoned with no ack, and the PIO strobes deassert asynchronously.

## Timing
- Reset values:
  - ack=0, busy=0, grant_idx=0, rr_ptr=0, rb_err=0
  - pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0
- All PIO outputs are registered; no combinational path from req to the PIO.
- Request seen high in cycle T (IDLE):
  - PIO write strobe in cycle T+1.
  - Read-back in T+2, when built in.
  - ack in T+2 without readback, T+3 with readback.
- Throughput: one LED update per 3 cycles without readback, per 4 cycles with readback.
- The PIO register reflects the new value from cycle T+2 onward.
- busy is high from T+1 through the ACK cycle inclusive.

## Configuration
- LEDR_ARB_READBACK_EN defined:
  - READ state present; rb_err and err_clr are functional.
  - Request-to-ack latency is 3 cycles.
- LEDR_ARB_READBACK_EN undefined:
  - READ state removed; pio_readdata is unused.
  - rb_err is tied 0 and err_clr is ignored.
  - Request-to-ack latency is 2 cycles.

## Test plan
- Reset, then single request: NREQ=2, req[0]=1 with data 10'h2A5 -> one PIO write of 32'h000002A5 at address 0, ack[0] pulses once, PIO holds 10'h2A5.
- Contention: req[0] and req[1] both held high continuously -> grants alternate 0,1,0,1. Each ack is exactly one cycle, writes are spaced 3 (or 4) cycles apart.
- Withdrawn request: req[1] pulses for one cycle while requester 0 is being served -> no write and no ack for requester 1. rr_ptr advances to 1, then grants 0 again.
- Readback mismatch (macro defined): bench forces pio_readdata=0 during READ while data is 10'h3FF -> rb_err=1 and stays set. err_clr pulse -> rb_err=0 the next cycle.
- Reset mid-transaction: reset_n asserted low during WRITE -> pio_chipselect=0 and pio_write_n=1 immediately, no ack. After release, a new req[1] is served normally with grant_idx=1.
